// File: rtl/mc_core.sv
// Multicycle RV32 subset core (lw/sw/add/sub/and/or/slt/addi/andi/ori/slti/beq/jal), one shared memory port.
// 3-5 cycles per instruction with mem_ready high; wait states stretch FETCH/MEMREAD/MEMWRITE with the bus held.
module mc_core #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            reset,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_ready,
  output logic [XLEN-1:0] pc,
  output logic            retire,
  output logic            trap
);

  generate
    if (XLEN != 32) begin : g_bad_xlen
      $error("mc_core: XLEN must be 32");
    end
  endgenerate

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECR    = 4'd6;
  localparam logic [3:0] S_EXECI    = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BEQ      = 4'd9;
  localparam logic [3:0] S_JAL      = 4'd10;
  localparam logic [3:0] S_TRAP     = 4'd11;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_REG   = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  logic [3:0]      state, state_nxt, dec_state;
  logic [XLEN-1:0] ir, old_pc, a, b, alu_out, mdr;
  logic [XLEN-1:0] rf [0:31];

  logic [6:0] opcode, f7;
  logic [2:0] f3;
  logic [4:0] rd, rs1, rs2;
  assign opcode = ir[6:0];
  assign rd     = ir[11:7];
  assign f3     = ir[14:12];
  assign rs1    = ir[19:15];
  assign rs2    = ir[24:20];
  assign f7     = ir[31:25];

  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_j;
  assign imm_i = {{(XLEN-12){ir[31]}}, ir[31:20]};
  assign imm_s = {{(XLEN-12){ir[31]}}, ir[31:25], ir[11:7]};
  assign imm_b = {{(XLEN-13){ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
  assign imm_j = {{(XLEN-21){ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};

  logic alu_f3_ok;
  assign alu_f3_ok = (f3 == 3'b000) || (f3 == 3'b111) || (f3 == 3'b110) || (f3 == 3'b010);

  // Anything not explicitly recognised, including bad funct fields, traps.
  always_comb begin
    dec_state = S_TRAP;
    case (opcode)
      OP_LOAD, OP_STORE: if (f3 == 3'b010) dec_state = S_MEMADR;
      OP_REG: if ((f7 == 7'b0000000 && alu_f3_ok) || (f7 == 7'b0100000 && f3 == 3'b000))
        dec_state = S_EXECR;
      OP_IMM: if (alu_f3_ok) dec_state = S_EXECI;
      OP_BR:  if (f3 == 3'b000) dec_state = S_BEQ;
      OP_JAL: dec_state = S_JAL;
      default: dec_state = S_TRAP;
    endcase
  end

  logic [XLEN-1:0] alu_b, alu_res, mem_ea;
  logic            alu_sub;
  assign alu_b   = (state == S_EXECR) ? b : imm_i;
  assign alu_sub = (state == S_EXECR) && f7[5];
  assign mem_ea  = a + ((opcode == OP_STORE) ? imm_s : imm_i);

  always_comb begin
    alu_res = a + alu_b;
    case (f3)
      3'b000: alu_res = alu_sub ? (a - alu_b) : (a + alu_b);
      3'b111: alu_res = a & alu_b;
      3'b110: alu_res = a | alu_b;
      3'b010: alu_res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(alu_b))};
      default: alu_res = a + alu_b;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH:    if (mem_ready) state_nxt = S_DECODE;
      S_DECODE:   state_nxt = dec_state;
      S_MEMADR:   state_nxt = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (mem_ready) state_nxt = S_MEMWB;
      S_MEMWRITE: if (mem_ready) state_nxt = S_FETCH;
      S_EXECR, S_EXECI, S_JAL: state_nxt = S_ALUWB;
      S_ALUWB, S_MEMWB, S_BEQ: state_nxt = S_FETCH;
      S_TRAP:     state_nxt = S_TRAP;
      default:    state_nxt = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_FETCH;
      pc    <= RESET_PC;
      trap  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == S_FETCH && mem_ready) pc <= pc + XLEN'(4);
      if (state == S_JAL) pc <= old_pc + imm_j;
      if (state == S_BEQ && a == b) pc <= old_pc + imm_b;
      if (state == S_DECODE && dec_state == S_TRAP) trap <= 1'b1;
    end
  end

  // Datapath and register file are deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (state == S_FETCH && mem_ready) begin
      ir     <= mem_rdata;
      old_pc <= pc;
    end
    if (state == S_DECODE) begin
      a <= (rs1 == 5'd0) ? '0 : rf[rs1];
      b <= (rs2 == 5'd0) ? '0 : rf[rs2];
    end
    if (state == S_MEMADR) alu_out <= mem_ea;
    if (state == S_EXECR || state == S_EXECI) alu_out <= alu_res;
    if (state == S_JAL) alu_out <= old_pc + XLEN'(4);
    if (state == S_MEMREAD && mem_ready) mdr <= mem_rdata;
    if (state == S_ALUWB && rd != 5'd0) rf[rd] <= alu_out;
    if (state == S_MEMWB && rd != 5'd0) rf[rd] <= mdr;
  end

  assign mem_req   = !reset && (state == S_FETCH || state == S_MEMREAD || state == S_MEMWRITE);
  assign mem_we    = !reset && (state == S_MEMWRITE);
  assign mem_addr  = (state == S_FETCH) ? pc : alu_out;
  assign mem_wdata = b;
  assign retire    = !reset && (state == S_ALUWB || state == S_MEMWB || state == S_BEQ ||
                                (state == S_MEMWRITE && mem_ready));

endmodule
